// File: rtl/hist_pkg.sv
// Shared definitions for the histogram readout serializer: default geometry,
// frame constants, FSM state encoding and the checksum helper.
package hist_pkg;

    localparam int          HIST_NWORDS   = 32;
    localparam int          HIST_WORDW    = 32;
    localparam logic [7:0]  HIST_HDR_BYTE = 8'hA5;

    // Header + all data bytes + checksum byte.
    localparam int          HIST_FRAME_LEN = 2 + HIST_NWORDS * HIST_WORDW / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Running frame checksum: plain byte sum, wrapping modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/hist_snapshot_reg.sv
// Wide capture register holding a coherent copy of the histogram, with a
// combinational word/byte read mux feeding the serializer.
module hist_snapshot_reg
    import hist_pkg::*;
#(
    parameter int NWORDS = HIST_NWORDS,
    parameter int WORDW  = HIST_WORDW,
    parameter int WIDX_W = $clog2(NWORDS),
    parameter int BIDX_W = $clog2(WORDW / 8)
) (
    input  logic                      clkin,
    input  logic                      rstn,
    input  logic                      load,
    input  logic [NWORDS*WORDW-1:0]   din,
    input  logic [WIDX_W-1:0]         word_sel,
    input  logic [BIDX_W-1:0]         byte_sel,
    output logic [7:0]                rd_byte
);

    logic [NWORDS*WORDW-1:0] snap_r;

    // Capture every histogram word in a single cycle when loading.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            snap_r <= {(NWORDS*WORDW){1'b0}};
        end else if (load) begin
            snap_r <= din;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Select byte byte_sel (LSB first) of word word_sel.
    always_comb begin
        rd_byte = 8'h00;
        rd_byte = snap_r[(int'(word_sel) * WORDW) + (int'(byte_sel) * 8) +: 8];
    end

endmodule

// File: rtl/hist_readout_serializer.sv
// Histogram readout serializer: snapshots the histogram on request and
// streams HDR, all words little-endian and a byte-sum checksum over a
// valid/ready byte link, optionally pulsing a histogram clear at the end.
module hist_readout_serializer
    import hist_pkg::*;
#(
    parameter int         NWORDS   = HIST_NWORDS,
    parameter int         WORDW    = HIST_WORDW,
    parameter logic [7:0] HDR_BYTE = HIST_HDR_BYTE
) (
    input  logic                      clkin,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      clear_after,
    input  logic [NWORDS*WORDW-1:0]   hist_flat,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      resethist,
    output logic                      done
);

    localparam int BYTES  = WORDW / 8;
    localparam int WIDX_W = $clog2(NWORDS);
    localparam int BIDX_W = $clog2(BYTES);

    state_t              state_r, state_nx_s;
    logic [WIDX_W-1:0]   word_r, word_nx_s;
    logic [BIDX_W-1:0]   byte_r, byte_nx_s;
    logic [7:0]          csum_r, csum_nx_s;
    logic                clr_r, clr_nx_s;
    logic [7:0]          tx_data_r, tx_data_nx_s;
    logic                tx_valid_r, tx_valid_nx_s;
    logic                busy_r, resethist_r, done_r;
    logic                load_s, xfer_s;
    logic [7:0]          rd_byte_s;

    // The read mux is addressed with the next indices so tx_data can be registered.
    hist_snapshot_reg #(
        .NWORDS (NWORDS),
        .WORDW  (WORDW),
        .WIDX_W (WIDX_W),
        .BIDX_W (BIDX_W)
    ) u_snap (
        .clkin    (clkin),
        .rstn     (rstn),
        .load     (load_s),
        .din      (hist_flat),
        .word_sel (word_nx_s),
        .byte_sel (byte_nx_s),
        .rd_byte  (rd_byte_s)
    );

    assign xfer_s = tx_valid_r && tx_ready;

    // Next-state, index and checksum logic; the byte on the link only advances on a transfer.
    always_comb begin
        state_nx_s = state_r;
        word_nx_s  = word_r;
        byte_nx_s  = byte_r;
        csum_nx_s  = csum_r;
        clr_nx_s   = clr_r;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    clr_nx_s   = clear_after;
                    word_nx_s  = {WIDX_W{1'b0}};
                    byte_nx_s  = {BIDX_W{1'b0}};
                    csum_nx_s  = 8'h00;
                    state_nx_s = ST_HDR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    // tx_data_r is exactly the byte being accepted.
                    csum_nx_s = csum_add(csum_r, tx_data_r);
                    byte_nx_s = byte_r + BIDX_W'(1);
                    if (byte_r == BIDX_W'(BYTES - 1)) begin
                        word_nx_s = word_r + WIDX_W'(1);
                        if (word_r == WIDX_W'(NWORDS - 1)) begin
                            state_nx_s = ST_CSUM;
                        end else begin
                            state_nx_s = ST_DATA;
                        end
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_CSUM;
                end
            end
            ST_FIN: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Byte and valid presented during the next cycle, derived from the next state.
    always_comb begin
        tx_data_nx_s  = 8'h00;
        tx_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_HDR: begin
                tx_data_nx_s  = HDR_BYTE;
                tx_valid_nx_s = 1'b1;
            end
            ST_DATA: begin
                tx_data_nx_s  = rd_byte_s;
                tx_valid_nx_s = 1'b1;
            end
            ST_CSUM: begin
                tx_data_nx_s  = csum_nx_s;
                tx_valid_nx_s = 1'b1;
            end
            default: begin
                tx_data_nx_s  = 8'h00;
                tx_valid_nx_s = 1'b0;
            end
        endcase
    end

    // State, indices, checksum and registered outputs; reset abandons any frame.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            word_r      <= {WIDX_W{1'b0}};
            byte_r      <= {BIDX_W{1'b0}};
            csum_r      <= 8'h00;
            clr_r       <= 1'b0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            resethist_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            word_r      <= word_nx_s;
            byte_r      <= byte_nx_s;
            csum_r      <= csum_nx_s;
            clr_r       <= clr_nx_s;
            tx_data_r   <= tx_data_nx_s;
            tx_valid_r  <= tx_valid_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            resethist_r <= (state_nx_s == ST_FIN) && clr_nx_s;
            done_r      <= (state_nx_s == ST_FIN);
        end
    end

    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign busy      = busy_r;
    assign resethist = resethist_r;
    assign done      = done_r;

endmodule

// File: tb/tb_hist_readout_serializer.sv
// Directed self-checking bench for hist_readout_serializer.
module tb_hist_readout_serializer;

    localparam int NW = 32;
    localparam int WW = 32;
    localparam int FLEN = 2 + NW * WW / 8;

    logic               clkin = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic               clear_after = 1'b0;
    logic [NW*WW-1:0]   hist_flat = '0;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
    logic               busy;
    logic               resethist;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] words [NW];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          n_done, n_rh, rh_bad, done_cyc;

    always #5 clkin = ~clkin;

    hist_readout_serializer dut (
        .clkin       (clkin),
        .rstn        (rstn),
        .start       (start),
        .clear_after (clear_after),
        .hist_flat   (hist_flat),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .resethist   (resethist),
        .done        (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive hist_flat from words[] and build the expected frame.
    task automatic load_words();
        logic [7:0] b;
        logic [7:0] sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        sum = 8'h00;
        for (int k = 0; k < NW; k++) begin
            hist_flat[k*WW +: WW] = words[k];
            for (int j = 0; j < WW / 8; j++) begin
                b = words[k][j*8 +: 8];
                exp_q.push_back(b);
                sum = sum + b;
            end
        end
        exp_q.push_back(sum);
    endtask

    task automatic cmp_frame(input string tag, input int n);
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    // Start a frame and observe the link; optional random stalls, hist
    // scrambling, mid-frame start and reset after abort_at bytes.
    task automatic run_frame(input bit rnd, input bit vary, input bit clr,
                             input bit restart_mid, input int abort_at);
        bit         prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        n_done = 0; n_rh = 0; rh_bad = 0; done_cyc = -1;
        prev_stall = 1'b0; prev_data = 8'h00;
        start = 1'b1; clear_after = clr;
        @(posedge clkin); #1;
        start = 1'b0; clear_after = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clkin);
            if (vary) begin
                for (int k = 0; k < NW; k++) hist_flat[k*WW +: WW] = $urandom;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) chk("latency_valid", tx_valid, 1);
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_data);
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (resethist) begin
                n_rh++;
                if (!done) rh_bad++;
            end
            if (restart_mid) begin
                if (cyc == 20) begin start = 1'b1; clear_after = 1'b1; end
                if (cyc == 21) begin start = 1'b0; clear_after = 1'b0; end
            end
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                rstn = 1'b0;
                break;
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resethist", resethist, 0);
        chk("rst_data", tx_data, 8'h00);
        repeat (2) @(negedge clkin);
        rstn = 1'b1;
        @(negedge clkin);
        chk("idle_busy", busy, 0);

        // 1: ramp pattern, ready always high
        for (int k = 0; k < NW; k++) words[k] = 32'h0100_0000 * k + k;
        load_words();
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1);
        cmp_frame("t1", FLEN);
        chk("t1_w1b0", got_q[5], 8'h01);
        chk("t1_w1b3", got_q[8], 8'h01);
        chk("t1_csum", got_q[FLEN-1], 8'hE0);
        chk("t1_done_cycle", done_cyc, 131);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_resethist", n_rh, 0);
        chk("t1_busy_end", busy, 0);

        // 2: random backpressure
        repeat (3) @(negedge clkin);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1);
        cmp_frame("t2", FLEN);
        chk("t2_done_cnt", n_done, 1);
        chk("t2_resethist", n_rh, 0);

        // 3: histogram changes every cycle after capture
        repeat (3) @(negedge clkin);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, -1);
        cmp_frame("t3", FLEN);
        chk("t3_done_cnt", n_done, 1);

        // 4: clear after readout
        load_words();
        repeat (3) @(negedge clkin);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, -1);
        cmp_frame("t4", FLEN);
        chk("t4_done_cnt", n_done, 1);
        chk("t4_resethist_cnt", n_rh, 1);
        chk("t4_resethist_with_done", rh_bad, 0);

        // 5: ignored mid-frame start, then reset after 60 bytes
        repeat (3) @(negedge clkin);
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 60);
        #1;
        chk("t5_rst_valid", tx_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_resethist", resethist, 0);
        cmp_frame("t5_prefix", 60);
        @(negedge clkin);
        rstn = 1'b1;
        n_done = 0; n_rh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clkin);
            if (done) n_done++;
            if (resethist) n_rh++;
            chk("t5_post_valid", tx_valid, 0);
        end
        chk("t5_post_done", n_done, 0);
        chk("t5_post_resethist", n_rh, 0);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1);
        cmp_frame("t5_next", FLEN);
        chk("t5_next_done_cnt", n_done, 1);
        chk("t5_next_resethist", n_rh, 0);

        // 6: all ones
        for (int k = 0; k < NW; k++) words[k] = 32'hFFFF_FFFF;
        load_words();
        repeat (3) @(negedge clkin);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1);
        cmp_frame("t6", FLEN);
        chk("t6_csum", got_q.size() == FLEN ? got_q[FLEN-1] : 8'h00, 8'h80);
        chk("t6_done_cnt", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
